// File: rtl/pixel_shuffle_2x_writer.sv
// 2x depth-to-space writer: packs 4-channel CNN pixels into a 2Wx2H byte image in word SRAM.
// Define PS2X_BOTTOM_UP_EN to write output rows in bottom-up (BMP) order.
module pixel_shuffle_2x_writer #(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 128,
  parameter int W_ADDR     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_ADDR-1:0] base_addr,
  input  logic [31:0]       in_pixel,
  input  logic              in_valid,
  output logic              wr_en,
  output logic [W_ADDR-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int XW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = W_ADDR + 32;
  localparam logic [W_ADDR-1:0] ROW_STEP = W_ADDR'(WIDTH);
  localparam logic [W_ADDR-1:0] HALF     = W_ADDR'(WIDTH / 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_next;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [W_ADDR-1:0] row_base;
  logic [31:0]       hold;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     free;
  logic [CW-1:0]     n_store;

  logic              accept, last_x, last_y, pair, push, drop;
  logic              out_load, from_mem, bypass, fifo_empty, done_next;
  logic [W_ADDR-1:0] col, top_addr, bot_addr, row_next, row_init;
  logic [31:0]       top_data, bot_data;

  assign accept     = (state == RUN) && in_valid;
  assign last_x     = (x == XW'(WIDTH - 1));
  assign last_y     = (y == YW'(HEIGHT - 1));
  assign pair       = accept && x[0];
  assign free       = CW'(FIFO_DEPTH) - count;
  assign push       = pair && (free >= CW'(2));
  assign drop       = pair && (free < CW'(2));
  assign out_load   = !wr_en || wr_ready;
  assign from_mem   = out_load && (count != '0);
  assign bypass     = out_load && (count == '0) && push;
  assign fifo_empty = (count == '0) && !wr_en;
  assign busy       = (state != IDLE);

  assign col      = W_ADDR'(x >> 1);
  assign top_data = {in_pixel[15:8], in_pixel[7:0], hold[15:8], hold[7:0]};
  assign bot_data = {in_pixel[31:24], in_pixel[23:16], hold[31:24], hold[23:16]};

  // The row-base accumulator holds the address of the top output row of the current input row.
`ifdef PS2X_BOTTOM_UP_EN
  assign row_init = base_addr + W_ADDR'((2 * HEIGHT - 1) * (WIDTH / 2));
  assign top_addr = row_base + col;
  assign bot_addr = row_base - HALF + col;
  assign row_next = row_base - ROW_STEP;
`else
  assign row_init = base_addr;
  assign top_addr = row_base + col;
  assign bot_addr = row_base + HALF + col;
  assign row_next = row_base + ROW_STEP;
`endif

  always_comb begin
    n_store = '0;
    if (push) n_store = bypass ? CW'(1) : CW'(2);
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE:  if (start) state_next = RUN;
      RUN:   if (accept && last_x && last_y) state_next = DRAIN;
      DRAIN: if (fifo_empty) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      row_base   <= '0;
      hold       <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_next;
      if (state == IDLE && start) begin
        x        <= '0;
        y        <= '0;
        row_base <= row_init;
        overflow <= 1'b0;
      end else if (accept) begin
        if (!x[0]) hold <= in_pixel;
        if (drop) overflow <= 1'b1;
        if (last_x) begin
          x        <= '0;
          y        <= y + YW'(1);
          row_base <= row_next;
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

  // Older stored words drain first; a fresh top word skips storage only when nothing is queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (out_load) begin
        if (from_mem) begin
          wr_en              <= 1'b1;
          {wr_addr, wr_data} <= mem[rd_ptr];
        end else if (bypass) begin
          wr_en   <= 1'b1;
          wr_addr <= top_addr;
          wr_data <= top_data;
        end else begin
          wr_en <= 1'b0;
        end
      end
      rd_ptr <= rd_ptr + PW'(from_mem);
      wr_ptr <= wr_ptr + PW'(n_store);
      count  <= count + n_store - CW'(from_mem);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      if (bypass) begin
        mem[wr_ptr] <= {bot_addr, bot_data};
      end else begin
        mem[wr_ptr]          <= {top_addr, top_data};
        mem[wr_ptr + PW'(1)] <= {bot_addr, bot_data};
      end
    end
  end

endmodule

// File: tb/tb_pixel_shuffle_2x_writer.sv
// Scoreboard bench for pixel_shuffle_2x_writer: a depth-to-space image model predicts every SRAM write.
module tb_pixel_shuffle_2x_writer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int WA    = 16;
  localparam int DEPTH = 2;
  localparam int NPIX  = W * H;
  localparam int NPAIR = NPIX / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WA-1:0] base_addr;
  logic [31:0]   in_pixel;
  logic          in_valid;
  logic          wr_en;
  logic [WA-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          wr_ready;
  logic          busy;
  logic          frame_done;
  logic          overflow;

  pixel_shuffle_2x_writer #(
    .WIDTH(W), .HEIGHT(H), .W_ADDR(WA), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_pixel(in_pixel), .in_valid(in_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int          done_count = 0;
  int          ready_mode = 0;
  logic [47:0] exp_q[$];
  logic [47:0] exp_word;
  logic [31:0] frame_pix [NPIX];
  bit          skip_pair [NPAIR];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: scatter every channel byte into a 2W x 2H image, then read the words back
  // in the order the writer emits them (per input pixel pair: upper row, then lower row).
  task automatic buildExpected(input logic [WA-1:0] base);
    logic [7:0]    img [2*H][2*W];
    logic [31:0]   word;
    logic [WA-1:0] addr;
    int            rr;
    for (int py = 0; py < H; py++)
      for (int px = 0; px < W; px++)
        for (int k = 0; k < 4; k++)
          img[2*py + k/2][2*px + k%2] = frame_pix[py*W + px][8*k +: 8];
    for (int py = 0; py < H; py++)
      for (int j = 0; j < W/2; j++)
        if (!skip_pair[py*(W/2) + j])
          for (int half = 0; half < 2; half++) begin
            for (int b = 0; b < 4; b++) word[8*b +: 8] = img[2*py + half][4*j + b];
`ifdef PS2X_BOTTOM_UP_EN
            rr = 2*H - 1 - (2*py + half);
`else
            rr = 2*py + half;
`endif
            addr = base + WA'(rr * (W/2) + j);
            exp_q.push_back({addr, word});
          end
  endtask

  task automatic startFrame(input logic [WA-1:0] base);
    done_count = 0;
    base_addr  = base;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input int gap);
    in_valid = 1'b1;
    in_pixel = frame_pix[idx];
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic endFrame(input string name, input logic exp_ovf);
    int waited = 0;
    while (done_count == 0 && waited < 300) begin
      tick();
      waited++;
    end
    if (done_count == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: frame_done not seen within %0d cycles", name, waited);
    end
    repeat (3) tick();
    checkOutput({name, "_done_count"}, 64'(done_count), 64'd1);
    checkOutput({name, "_words_left"}, 64'(exp_q.size()), 64'd0);
    checkOutput({name, "_overflow"}, 64'(overflow), 64'(exp_ovf));
    checkOutput({name, "_busy"}, 64'(busy), 64'd0);
    exp_q.delete();
  endtask

  task automatic specPattern();
    logic [7:0] v;
    for (int py = 0; py < H; py++)
      for (int px = 0; px < W; px++) begin
        v = 8'(16*py + 4*px);
        frame_pix[py*W + px] = {v, v, v, v} + 32'h03020100;
      end
  endtask

  task automatic randomPattern();
    for (int i = 0; i < NPIX; i++) frame_pix[i] = $urandom;
  endtask

  task automatic clearSkips();
    for (int i = 0; i < NPAIR; i++) skip_pair[i] = 1'b0;
  endtask

  task automatic runFrame(input string name, input logic [WA-1:0] base,
                          input int min_gap, input int max_gap, input int rmode);
    ready_mode = rmode;
    clearSkips();
    buildExpected(base);
    tick();
    startFrame(base);
    for (int i = 0; i < NPIX; i++) applyStimulus(i, $urandom_range(max_gap, min_gap));
    endFrame(name, 1'b0);
  endtask

  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = !wr_ready;
        2:       wr_ready = wr_ready ? ($urandom_range(1, 0) == 1) : 1'b1;
        default: wr_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every accepted write must match the oldest predicted word.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en && wr_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL write_extra: got addr %0h data %0h, expected no write", wr_addr, wr_data);
        end else begin
          exp_word = exp_q.pop_front();
          checkOutput("write_addr", 64'(wr_addr), 64'(exp_word[47:32]));
          checkOutput("write_data", 64'(wr_data), 64'(exp_word[31:0]));
        end
      end
      if (frame_done) begin
        done_count++;
        checkOutput("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    in_pixel  = '0;
    in_valid  = 1'b0;
    repeat (3) tick();
    checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
    checkOutput("rst_wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("rst_wr_data", 64'(wr_data), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_frame_done", 64'(frame_done), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    $display("[TB] single frame, base 0x100");
    specPattern();
    runFrame("single", 16'h0100, 0, 0, 0);

    $display("[TB] backpressure frame");
    runFrame("backpressure", 16'h0100, 2, 2, 1);

    $display("[TB] overflow frame");
    ready_mode = 3;
    repeat (3) tick();
    clearSkips();
    skip_pair[1] = 1'b1;
    buildExpected(16'h0040);
    startFrame(16'h0040);
    for (int i = 0; i < 4; i++) applyStimulus(i, 0);
    checkOutput("ovf_flag_set", 64'(overflow), 64'd1);
    ready_mode = 0;
    repeat (4) tick();
    for (int i = 4; i < NPIX; i++) applyStimulus(i, 0);
    endFrame("overflow", 1'b1);

    $display("[TB] start while busy, then reset mid-frame");
    ready_mode = 0;
    tick();
    clearSkips();
    skip_pair[2] = 1'b1;
    skip_pair[3] = 1'b1;
    buildExpected(16'h0200);
    startFrame(16'h0200);
    for (int i = 0; i < 3; i++) applyStimulus(i, 0);
    base_addr = 16'h0300;
    start     = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(3, 0);
    repeat (4) tick();
    checkOutput("restart_busy", 64'(busy), 64'd1);
    checkOutput("restart_words_left", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_wr_en", 64'(wr_en), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("midrst_no_done", 64'(done_count), 64'd0);
    exp_q.delete();
    runFrame("after_reset", 16'h0000, 0, 1, 0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 6; f++) begin
      randomPattern();
      if (f == 0) runFrame("rand_wrap", 16'hFFFC, 2, 4, 2);
      else if (f == 1) runFrame("rand_sustained", 16'($urandom), 0, 0, 0);
      else runFrame("rand", 16'($urandom), 2, 5, 2);
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
